// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
package regfile_pkg;

  typedef enum logic {IDLE, CLEAR} rf_clr_state_t;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_param_if.sv
// Register-file access bundle: read ports, WB write port, issue scoreboard and clear control.
interface regfile_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
);

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_pending;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_addr;
  logic                  clr_req;
  logic                  clr_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, clr_req,
    input  rd_data, rd_pending, clr_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, clr_req,
    output rd_data, rd_pending, clr_busy
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks registers 1..NREGS-1, zeroing one per cycle while busy.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_start,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NREGS - 1);

  rf_clr_state_t     state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          cnt_d     = ADDR_W'(1);
          clr_start = 1'b1;
        end
      end
      CLEAR: begin
        // Stop on the last register rather than letting the counter wrap.
        if (cnt_q == LastAddr) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy = (state_q == CLEAR);
  assign clr_we   = clr_busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with pending scoreboard and bulk clear.
// Define RF_BYPASS_EN to forward a same-cycle qualifying write to matching read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2
) (
  input logic              clk,
  input logic              reset,
  regfile_param_if.slave   bus
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic              clr_busy, clr_start, clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok, sb_ok;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;

  regfile_clr_seq #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_clr_seq (
    .clk       (clk),
    .reset     (reset),
    .clr_req   (bus.clr_req),
    .clr_busy  (clr_busy),
    .clr_start (clr_start),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign bus.clr_busy = clr_busy;
  assign wr_ok = bus.wr_en && (bus.wr_addr != ZeroAddr) && !clr_busy;
  assign sb_ok = bus.sb_set && (bus.sb_addr != ZeroAddr) && !clr_busy;

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= '0;
    end else if (clr_we) begin
      regs_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Set after clear so a newer producer issued alongside the retiring write wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_start) begin
      pending_d = '0;
    end else begin
      if (wr_ok) pending_d[bus.wr_addr] = 1'b0;
      if (sb_ok) pending_d[bus.sb_addr] = 1'b1;
    end
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              pend;

    assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs_q[addr];
      pend = pending_q[addr];
`ifdef RF_BYPASS_EN
      if (wr_ok && (bus.wr_addr == addr)) begin
        data = bus.wr_data;
        pend = sb_ok && (bus.sb_addr == addr);
      end
`endif
      if (addr == ZeroAddr) begin
        data = '0;
        pend = 1'b0;
      end
    end

    assign bus.rd_data[i*DATA_W +: DATA_W] = data;
    assign bus.rd_pending[i]               = pend;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_param;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;
  localparam int unsigned NP = 2;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NP)) bus ();

  regfile_param #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NREGS  (NR),
    .NRD    (NP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_busy;
    int          port;
    logic [31:0] data;
    logic        pend;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] got_d;
  logic        got_p;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_tests++;
      if (mon_e.is_busy) begin
        if (bus.clr_busy !== mon_e.pend) begin
          n_fail++;
          $display("FAIL %s: clr_busy=%0b expected %0b", mon_e.name, bus.clr_busy, mon_e.pend);
        end
      end else begin
        got_d = bus.rd_data[mon_e.port*DW +: DW];
        got_p = bus.rd_pending[mon_e.port];
        if (got_d !== mon_e.data || got_p !== mon_e.pend) begin
          n_fail++;
          $display("FAIL %s: port%0d data=%h pend=%b expected data=%h pend=%b", mon_e.name,
                   mon_e.port, got_d, got_p, mon_e.data, mon_e.pend);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input int wa, input logic [31:0] wd, input logic ss,
                       input int sa, input logic cr);
    bus.wr_en   = we;
    bus.wr_addr = wa[AW-1:0];
    bus.wr_data = wd;
    bus.sb_set  = ss;
    bus.sb_addr = sa[AW-1:0];
    bus.clr_req = cr;
  endtask

  task automatic idle();
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int port, input int addr, input logic [31:0] d, input logic p,
                    input string nm);
    exp_t e;
    bus.rd_addr[port*AW +: AW] = addr[AW-1:0];
    e.is_busy = 1'b0;
    e.port    = port;
    e.data    = d;
    e.pend    = p;
    e.name    = nm;
    sb_q.push_back(e);
  endtask

  task automatic exp_busy(input logic b, input string nm);
    exp_t e;
    e.is_busy = 1'b1;
    e.port    = 0;
    e.data    = 32'h0;
    e.pend    = b;
    e.name    = nm;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.rd_addr = '0;
    idle();
    repeat (2) step();
    reset = 1'b0;

    // Reset contents on every address, both ports.
    exp_busy(1'b0, "t1_busy");
    for (int a = 0; a < int'(NR); a++) begin
      rd(0, a, 32'h0, 1'b0, "t1_p0");
      rd(1, int'(NR) - 1 - a, 32'h0, 1'b0, "t1_p1");
      step();
    end

    // Basic write and reg-0 discard.
    drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    step();
    idle();
    rd(0, 5, 32'hDEADBEEF, 1'b0, "t2_wr5");
    step();
    drive(1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
    step();
    idle();
    rd(1, 0, 32'h0, 1'b0, "t2_wr0");
    step();

    // Same-cycle write/read.
    drive(1'b1, 7, 32'h1234, 1'b0, 0, 1'b0);
    rd(0, 7, BYP ? 32'h1234 : 32'h0, 1'b0, "t3_same");
    step();
    idle();
    rd(0, 7, 32'h1234, 1'b0, "t3_next");
    step();

    // Scoreboard set/clear and set-wins collision.
    drive(1'b0, 0, 32'h0, 1'b1, 9, 1'b0);
    step();
    idle();
    rd(1, 9, 32'h0, 1'b1, "t4_set");
    step();
    drive(1'b1, 9, 32'hAA, 1'b0, 0, 1'b0);
    rd(1, 9, BYP ? 32'hAA : 32'h0, BYP ? 1'b0 : 1'b1, "t4_wr_same");
    step();
    idle();
    rd(1, 9, 32'hAA, 1'b0, "t4_wr_next");
    step();
    drive(1'b1, 9, 32'hBB, 1'b1, 9, 1'b0);
    rd(1, 9, BYP ? 32'hBB : 32'hAA, BYP ? 1'b1 : 1'b0, "t4_both_same");
    step();
    idle();
    rd(1, 9, 32'hBB, 1'b1, "t4_both_next");
    step();

    // Fill 1..31 with index; mark reg 3 pending after its write.
    for (int a = 1; a < int'(NR); a++) begin
      drive(1'b1, a, 32'(a), a == 20, 3, 1'b0);
      step();
    end
    idle();
    rd(0, 31, 32'd31, 1'b0, "t5_fill31");
    rd(1, 3, 32'd3, 1'b1, "t5_pend3");
    step();

    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b1);
    exp_busy(1'b0, "t5_busy_c0");
    step();
    idle();
    for (int c = 1; c < int'(NR); c++) begin
      exp_busy(1'b1, "t5_busy");
      if (c == 1)  rd(0, 3, 32'd3, 1'b0, "t5_pend_clr");
      if (c == 5) begin
        rd(0, 4, 32'h0, 1'b0, "t5_part_lo");
        rd(1, 6, 32'd6, 1'b0, "t5_part_hi");
      end
      if (c == 10) begin
        drive(1'b1, 2, 32'h5555, 1'b1, 2, 1'b0);
        rd(1, 2, 32'h0, 1'b0, "t5_mid_wr");
      end
      if (c == 11) drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b1);
      if (c == 12) idle();
      step();
    end
    exp_busy(1'b0, "t5_busy_end");
    for (int a = 0; a < int'(NR); a++) begin
      rd(0, a, 32'h0, 1'b0, "t5_zero_p0");
      rd(1, int'(NR) - 1 - a, 32'h0, 1'b0, "t5_zero_p1");
      step();
    end
    exp_busy(1'b0, "t5_no_restart");
    step();

    // Async reset in the middle of a clear.
    drive(1'b1, 31, 32'h31, 1'b0, 0, 1'b0);
    step();
    drive(1'b1, 30, 32'h30, 1'b0, 0, 1'b0);
    step();
    drive(1'b0, 0, 32'h0, 1'b1, 17, 1'b0);
    step();
    drive(1'b0, 0, 32'h0, 1'b0, 0, 1'b1);
    step();
    idle();
    repeat (9) step();
    reset = 1'b1;
    exp_busy(1'b0, "t6_rst_busy");
    rd(0, 31, 32'h0, 1'b0, "t6_rst_r31");
    rd(1, 17, 32'h0, 1'b0, "t6_rst_p17");
    step();
    rd(0, 30, 32'h0, 1'b0, "t6_rst_r30");
    step();
    reset = 1'b0;
    drive(1'b1, 4, 32'h44, 1'b0, 0, 1'b0);
    exp_busy(1'b0, "t6_post_busy");
    step();
    idle();
    rd(0, 4, 32'h44, 1'b0, "t6_idle_wr");
    rd(1, 31, 32'h0, 1'b0, "t6_post_r31");
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
